// File: rtl/dpram_pkg.sv
// Shared constants and the state type for the clearable dual-port RAM.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dpram_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 3;

  // Clear sequencer states: ST_IDLE serves user traffic, ST_CLEAR walks the array.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/dpram_clr_seq.sv
// Clear sequencer: walks the array writing zero once per cycle, starting at address 0.
// Latency: busy rises the cycle after clr_req; a clear lasts exactly DEPTH cycles.
// Backpressure: none; clr_req during a running clear is ignored and the walk is not restarted.
module dpram_clr_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;

  // Reset lands in CLEAR so the array is zeroed automatically after rst_n releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign clr_busy = (state == ST_CLEAR);
  assign clr_we   = clr_busy;
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/dpram_clr_param.sv
// Simple dual-port RAM (one write, one read port) with a hardware clear sequencer.
// Latency: read data and rvalid one cycle after re; writes land at the clock edge.
// Backpressure: none; writes during clear, colliding with clr_req or out of range are dropped and flagged.
module dpram_clr_param
  import dpram_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = 8,
  parameter int RDW_NEW   = 0,
  parameter int ZERO_IDLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wr_drop
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              waddr_ok;
  logic              raddr_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic              rdw_hit;

  dpram_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign waddr_ok = ({1'b0, waddr} < DEPTH_EXT);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);
  // A pending clr_req wins over a same-cycle user write.
  assign wr_acc   = we && !clr_busy && !clr_req && waddr_ok;
  assign rd_acc   = re && !clr_busy;
  assign rdw_hit  = (RDW_NEW != 0) && wr_acc && (waddr == raddr);

  // Storage: the clear walk owns the write port while busy, otherwise user writes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read path, read-valid strobe and dropped-write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata   <= '0;
      rvalid  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= we && !wr_acc;
      rvalid  <= rd_acc;
      if (rd_acc) begin
        if (!raddr_ok) begin
          rdata <= '0;
        end else if (rdw_hit) begin
          rdata <= wdata;
        end else begin
          rdata <= mem[raddr];
        end
      end else if (ZERO_IDLE != 0) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_clr_param.sv
// Bench for dpram_clr_param: three builds share one stimulus stream.
// Build 0: DEPTH 8, old-data read-during-write, zero when idle.
// Build 1: DEPTH 8, new-data bypass, hold when idle.  Build 2: DEPTH 6, old-data, zero when idle.
module tb_dpram_clr_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_req;
  logic       we;
  logic [2:0] waddr;
  logic [9:0] wdata;
  logic       re;
  logic [2:0] raddr;

  logic [9:0] rdata_o   [3];
  logic       rvalid_o  [3];
  logic       wr_drop_o [3];
  logic       busy_o    [3];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         dut;
    logic [9:0] rdata;
    logic       rvalid;
    logic       wr_drop;
    bit         chk_rdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dpram_clr_param #(.DATA_W(10), .ADDR_W(3), .DEPTH(8), .RDW_NEW(0), .ZERO_IDLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy_o[0]),
    .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .wr_drop(wr_drop_o[0])
  );

  dpram_clr_param #(.DATA_W(10), .ADDR_W(3), .DEPTH(8), .RDW_NEW(1), .ZERO_IDLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy_o[1]),
    .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .wr_drop(wr_drop_o[1])
  );

  dpram_clr_param #(.DATA_W(10), .ADDR_W(3), .DEPTH(6), .RDW_NEW(0), .ZERO_IDLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy_o[2]),
    .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata_o[2]), .rvalid(rvalid_o[2]), .wr_drop(wr_drop_o[2])
  );

  function automatic int dep(int d);
    return (d == 2) ? 6 : 8;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(logic c, logic w, logic [2:0] wa, logic [9:0] wd, logic r, logic [2:0] ra);
    clr_req = c;
    we      = w;
    waddr   = wa;
    wdata   = wd;
    re      = r;
    raddr   = ra;
  endtask

  task automatic push(string tag, int d, logic [9:0] rd, logic rv, logic wdr, bit chk);
    exp_t e;
    e.tag       = tag;
    e.dut       = d;
    e.rdata     = rd;
    e.rvalid    = rv;
    e.wr_drop   = wdr;
    e.chk_rdata = chk;
    sb.push_back(e);
  endtask

  // Same expectation for all builds; the holding build's rdata is only checked on reads.
  task automatic push_all(string tag, logic [9:0] rd, logic rv, logic wdr);
    push(tag, 0, rd, rv, wdr, 1'b1);
    push(tag, 1, rd, rv, wdr, rv);
    push(tag, 2, rd, rv, wdr, 1'b1);
  endtask

  // Advance one clock, then compare every expectation queued for that edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check($sformatf("%s[%0d].rvalid", e.tag, e.dut), rvalid_o[e.dut], e.rvalid);
      check($sformatf("%s[%0d].wr_drop", e.tag, e.dut), wr_drop_o[e.dut], e.wr_drop);
      if (e.chk_rdata)
        check($sformatf("%s[%0d].rdata", e.tag, e.dut), rdata_o[e.dut], e.rdata);
    end
  endtask

  task automatic count_busy(output int c0, output int c1, output int c2);
    c0 = 0;
    c1 = 0;
    c2 = 0;
    for (int k = 0; k < 50; k++) begin
      if (!(busy_o[0] || busy_o[1] || busy_o[2])) break;
      if (busy_o[0]) c0++;
      if (busy_o[1]) c1++;
      if (busy_o[2]) c2++;
      tick();
    end
  endtask

  task automatic check_busy_len(string tag);
    int c0, c1, c2;
    count_busy(c0, c1, c2);
    check({tag, "[0]"}, c0, 8);
    check({tag, "[1]"}, c1, 8);
    check({tag, "[2]"}, c2, 6);
  endtask

  task automatic check_reset_outputs(string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s[%0d].rdata", tag, d), rdata_o[d], 10'h000);
      check($sformatf("%s[%0d].rvalid", tag, d), rvalid_o[d], 1'b0);
      check($sformatf("%s[%0d].wr_drop", tag, d), wr_drop_o[d], 1'b0);
      check($sformatf("%s[%0d].busy", tag, d), busy_o[d], 1'b1);
    end
  endtask

  task automatic read_all_zero(string tag);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b1, 3'(i));
      push_all($sformatf("%s@%0d", tag, i), 10'h000, 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    check_busy_len("busy_after_reset");
    read_all_zero("rd_init");

    // Basic write/read; address 7 is out of range for the 6-deep build.
    drive(1'b0, 1'b1, 3'd2, 10'h3A5, 1'b0, 3'd0);
    push_all("wr2", 10'h000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 3'd7, 10'h155, 1'b0, 3'd0);
    push("wr7", 0, 10'h000, 1'b0, 1'b0, 1'b1);
    push("wr7", 1, 10'h000, 1'b0, 1'b0, 1'b0);
    push("wr7", 2, 10'h000, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b1, 3'd2);
    push_all("rd2", 10'h3A5, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b1, 3'd7);
    push("rd7", 0, 10'h155, 1'b1, 1'b0, 1'b1);
    push("rd7", 1, 10'h155, 1'b1, 1'b0, 1'b1);
    push("rd7", 2, 10'h000, 1'b1, 1'b0, 1'b1);
    tick();
    // Idle cycle: zeroing builds return 0, the holding build keeps 155.
    drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
    push("idle", 0, 10'h000, 1'b0, 1'b0, 1'b1);
    push("idle", 1, 10'h155, 1'b0, 1'b0, 1'b1);
    push("idle", 2, 10'h000, 1'b0, 1'b0, 1'b1);
    tick();

    // Read-during-write to the same address.
    drive(1'b0, 1'b1, 3'd4, 10'h011, 1'b0, 3'd0);
    push_all("wr4", 10'h000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 3'd4, 10'h2F0, 1'b1, 3'd4);
    push("rdw", 0, 10'h011, 1'b1, 1'b0, 1'b1);
    push("rdw", 1, 10'h2F0, 1'b1, 1'b0, 1'b1);
    push("rdw", 2, 10'h011, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b1, 3'd4);
    push_all("rdw_after", 10'h2F0, 1'b1, 1'b0);
    tick();

    // Fill with 3FF, then clr_req colliding with a write and a read.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 10'h3FF, 1'b0, 3'd0);
      push($sformatf("fill@%0d", i), 0, 10'h000, 1'b0, 1'b0, 1'b1);
      push($sformatf("fill@%0d", i), 1, 10'h000, 1'b0, 1'b0, 1'b0);
      push($sformatf("fill@%0d", i), 2, 10'h000, 1'b0, (i >= 6), 1'b1);
      tick();
    end
    drive(1'b1, 1'b1, 3'd1, 10'h0AA, 1'b1, 3'd0);
    push_all("clr_coll", 10'h3FF, 1'b1, 1'b1);
    tick();
    for (int d = 0; d < 3; d++)
      check($sformatf("busy_rise[%0d]", d), busy_o[d], 1'b1);
    for (int j = 1; j <= 8; j++) begin
      if (j <= 6) begin
        drive(1'b0, 1'b1, 3'd3, 10'h0AA, 1'b1, 3'd0);
        push($sformatf("in_clr%0d", j), 0, 10'h000, 1'b0, 1'b1, 1'b1);
        push($sformatf("in_clr%0d", j), 1, 10'h3FF, 1'b0, 1'b1, 1'b1);
        push($sformatf("in_clr%0d", j), 2, 10'h000, 1'b0, 1'b1, 1'b1);
      end else begin
        drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
        push($sformatf("in_clr%0d", j), 0, 10'h000, 1'b0, 1'b0, 1'b1);
        push($sformatf("in_clr%0d", j), 1, 10'h3FF, 1'b0, 1'b0, 1'b1);
        push($sformatf("in_clr%0d", j), 2, 10'h000, 1'b0, 1'b0, 1'b1);
      end
      tick();
      for (int d = 0; d < 3; d++)
        check($sformatf("busy_clr%0d[%0d]", j, d), busy_o[d], (j + 1 <= dep(d)));
    end
    read_all_zero("rd_after_clr");

    // Reset in the fourth cycle of a clear.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 10'h123, 1'b0, 3'd0);
      push($sformatf("fill2@%0d", i), 0, 10'h000, 1'b0, 1'b0, 1'b1);
      push($sformatf("fill2@%0d", i), 1, 10'h000, 1'b0, 1'b0, 1'b0);
      push($sformatf("fill2@%0d", i), 2, 10'h000, 1'b0, (i >= 6), 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 10'h000, 1'b1, 3'd0);
    push_all("rd_pre", 10'h123, 1'b1, 1'b0);
    tick();
    for (int j = 0; j < 4; j++) begin
      drive((j == 0), 1'b0, 3'd0, 10'h000, 1'b0, 3'd0);
      push($sformatf("clr_go%0d", j), 0, 10'h000, 1'b0, 1'b0, 1'b1);
      push($sformatf("clr_go%0d", j), 1, 10'h123, 1'b0, 1'b0, 1'b1);
      push($sformatf("clr_go%0d", j), 2, 10'h000, 1'b0, 1'b0, 1'b1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_clr_reset");
    tick();
    tick();
    rst_n = 1'b1;
    check_busy_len("busy_restart");
    read_all_zero("rd_after_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_clr_param.md
Name: dpram_clr_param

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, single clock.
- Replaces the fixed 8x10 storage block used by the datapath.
- Adds a multi-cycle hardware clear sequencer with busy flag, automatic clear after reset and selectable read-during-write behaviour.
- Includes a registered read-valid strobe and a dropped-write indicator, so the controlling FSM no longer drives a raw state code into the RAM.

Parameters:
- DATA_W, 10, word width in bits.
- ADDR_W, 3, address width in bits.
- DEPTH, 8, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- RDW_NEW, 0, same-address read-during-write: 0 returns old data, 1 returns new data (bypass).
- ZERO_IDLE, 1, 1 forces rdata to 0 on cycles with no read; 0 holds the last rdata.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  single-cycle request to zero the whole array.
- clr_busy  out  1  high while the clear sequence runs.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  high the cycle after an accepted read.
- wr_drop  out  1  one-cycle pulse: the previous cycle's write was discarded.

Behaviour:
- Reset (rst_n low, async):
  - rdata=0, rvalid=0, wr_drop=0, clr_cnt=0.
  - FSM=CLEAR, clr_busy=1.
  - Array contents are not reset directly; they are zeroed by the clear sequence after rst_n deasserts.
- FSM states: IDLE, CLEAR.
- CLEAR:
  - Each cycle writes 0 to mem[clr_cnt], then clr_cnt increments.
  - When clr_cnt==DEPTH-1 is written, go to IDLE next cycle and reset clr_cnt to 0.
  - Duration is exactly DEPTH cycles; clr_busy is high for all of them.
- IDLE -> CLEAR when clr_req=1. clr_busy rises the next cycle.
- clr_req while already in CLEAR is ignored; the counter is not restarted.
- User write:
  - Accepted only in IDLE, with clr_req=0, we=1 and waddr<DEPTH.
  - Takes effect at the clock edge.
- Write dropped, with wr_drop=1 on the next cycle, when any of these holds:
  - we=1 in CLEAR;
  - we=1 together with clr_req=1 (clear wins);
  - waddr>=DEPTH.
- Read:
  - Accepted in IDLE with re=1.
  - Latency 1: rdata=mem[raddr] and rvalid=1 on the next edge.
  - raddr>=DEPTH returns rdata=0 with rvalid=1.
- re=1 in CLEAR: rvalid=0 next cycle; rdata=0 if ZERO_IDLE=1, otherwise held.
- re=0: rvalid=0; rdata=0 if ZERO_IDLE=1, otherwise held.
- Same-cycle read and accepted write to the same address:
  - RDW_NEW=0: old word.
  - RDW_NEW=1: wdata.
- Read in the same cycle as clr_req (IDLE) is still served, returning pre-clear data.
- Reset asserted mid-clear or mid-read: outputs go to reset values immediately. The clear restarts from address 0 after release.
- No arithmetic beyond clr_cnt, which is ADDR_W bits and compared against DEPTH-1. It never wraps past DEPTH-1.

Decomposition:
- Shared package dpram_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_CLEAR=1'b1;
  - default width constants DATA_W_DEF=10, ADDR_W_DEF=3.
- One natural sub-module: dpram_clr_seq.
  - Contains the FSM plus clr_cnt.
  - Outputs clr_busy, clr_we, clr_addr.
  - The top muxes clear writes over user writes and holds the storage array and read path.

Test Plan:
- Reset release: rst_n low 2 cycles then high; read all 8 addresses after clr_busy falls -> clr_busy high exactly 8 cycles, every read returns rdata=0, rvalid=1.
- Basic write/read: write 10'h3A5 @2 and 10'h155 @7, then read 2, 7 -> rdata 3A5 then 155, each one cycle after re, rvalid pulses aligned.
- Read-during-write: mem[4]=10'h011, same cycle we=1 wdata=10'h2F0 waddr=4 re=1 raddr=4 -> RDW_NEW=0 gives 011, RDW_NEW=1 gives 2F0; following read gives 2F0 in both builds.
- Clear collision: fill array with 10'h3FF, pulse clr_req with we=1 @1 data 10'h0AA -> wr_drop=1 next cycle, clr_busy 8 cycles, we during clear also pulses wr_drop, all words read 0 afterwards.
- Reset mid-clear: assert rst_n low on the 4th cycle of a clear, release -> outputs 0 immediately, full 8-cycle clear restarts from address 0, all words 0.
- Non-power-of-two: DEPTH=6, ADDR_W=3; write @6 -> wr_drop=1 and array unchanged; read @7 -> rdata=0, rvalid=1; clear lasts 6 cycles.
